vga_draw_arbiter: RTL and testbench

Round-robin arbiter that shares the single `vga_adapter` plot port among N independent draw engines (card frame, symbol, score, cancel-card painters). Each engine raises a request and receives an exclusive one-hot grant. The arbiter then forwards that engine's pixel stream (x/y/colour/plot) to the adapter until the engine signals done, abandons the request, or a watchdog expires. It sits between the game datapath's draw engines and `vga_adapter`, replacing ad-hoc select-code muxing.

---
 rtl/vga_draw_pkg.sv | 17 +
 rtl/vga_draw_arbiter_rr_pick.sv | 31 +++
 rtl/vga_draw_arbiter.sv | 128 ++++++++++++
 tb/tb_vga_draw_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared types and screen constants for the VGA draw arbiter.
package vga_draw_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [X_W-1:0] SCREEN_W = 8'd160;
    localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StActive  = 2'd1;
    localparam state_t StRelease = 2'd2;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OWN_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] ptr,
    output logic             valid,
    output logic [OWN_W-1:0] index
);

    logic [OWN_W:0] cand;

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (OWN_W + 1)'(i);
            if (cand >= (OWN_W + 1)'(N_REQ)) begin
                cand = cand - (OWN_W + 1)'(N_REQ);
            end
            if (req[cand[OWN_W-1:0]]) begin
                valid = 1'b1;
                index = cand[OWN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the vga_adapter plot port with registered pixel forwarding and watchdog.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WD_CYCLES = 32768,
    parameter int unsigned OWN_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [N_REQ-1:0]          plot_in,
    input  logic [X_W*N_REQ-1:0]      x_in,
    input  logic [Y_W*N_REQ-1:0]      y_in,
    input  logic [COLOUR_W*N_REQ-1:0] colour_in,
    output logic [N_REQ-1:0]          grant,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy,
    output logic [X_W-1:0]            x,
    output logic [Y_W-1:0]            y,
    output logic [COLOUR_W-1:0]       colour,
    output logic                      writeEn,
    output logic                      timeout_err
);

    localparam int unsigned WD_W = $clog2(WD_CYCLES);

    state_t            state_q;
    logic [OWN_W-1:0]  ptr_q;
    logic [WD_W-1:0]   watchdog_q;

    logic              pick_valid;
    logic [OWN_W-1:0]  pick_idx;

    logic [X_W-1:0]      x_sel;
    logic [Y_W-1:0]      y_sel;
    logic [COLOUR_W-1:0] colour_sel;
    logic                plot_sel;
    logic                done_sel;
    logic                req_sel;
    logic                on_screen;
    logic                wd_expire;
    logic                engine_exit;
    logic                exit_now;

    rr_pick #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        x_sel      = '0;
        y_sel      = '0;
        colour_sel = '0;
        plot_sel   = 1'b0;
        done_sel   = 1'b0;
        req_sel    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == OWN_W'(i)) begin
                x_sel      = x_in[i*X_W +: X_W];
                y_sel      = y_in[i*Y_W +: Y_W];
                colour_sel = colour_in[i*COLOUR_W +: COLOUR_W];
                plot_sel   = plot_in[i];
                done_sel   = done[i];
                req_sel    = req[i];
            end
        end
    end

    assign on_screen   = (x_sel < SCREEN_W) && (y_sel < SCREEN_H);
    assign wd_expire   = (watchdog_q == WD_W'(WD_CYCLES - 1));
    assign engine_exit = done_sel || !req_sel;
    assign exit_now    = engine_exit || wd_expire;
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            watchdog_q  <= '0;
            grant       <= '0;
            owner       <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            writeEn     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            writeEn     <= 1'b0;
            timeout_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner      <= pick_idx;
                        watchdog_q <= '0;
                        state_q    <= StActive;
                    end
                end
                StActive: begin
                    x      <= x_sel;
                    y      <= y_sel;
                    colour <= colour_sel;
                    if (exit_now) begin
                        grant       <= '0;
                        timeout_err <= !engine_exit;
                        state_q     <= StRelease;
                    end else begin
                        writeEn    <= plot_sel && on_screen;
                        watchdog_q <= watchdog_q + WD_W'(1);
                    end
                end
                StRelease: begin
                    ptr_q   <= (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + OWN_W'(1);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_vga_draw_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WD    = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N_REQ-1:0]  req, done, plot_in;
    logic [8*N_REQ-1:0] x_in;
    logic [7*N_REQ-1:0] y_in;
    logic [3*N_REQ-1:0] colour_in;
    logic [N_REQ-1:0]  grant;
    logic [1:0]        owner;
    logic              busy, writeEn, timeout_err;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;

    int n_checks = 0;
    int n_fail   = 0;

    vga_draw_arbiter #(
        .N_REQ     (N_REQ),
        .WD_CYCLES (WD),
        .OWN_W     (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .plot_in     (plot_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .grant       (grant),
        .owner       (owner),
        .busy        (busy),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEn     (writeEn),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = nobody owns, 1 = owning, 2 = one-cycle cool-down.
    bit         m_started = 1'b0;
    int         m_phase, m_ptr, m_age, m_win;
    bit         m_found, m_quit_engine, m_quit_wd;
    logic [N_REQ-1:0] e_grant;
    int         e_owner;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    logic       e_we, e_to;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!reset_n) begin
            m_phase = 0; m_ptr = 0; m_age = 0;
            e_grant = '0; e_owner = 0; e_x = '0; e_y = '0; e_col = '0;
            e_we = 1'b0; e_to = 1'b0;
        end else begin
            e_we = 1'b0;
            e_to = 1'b0;
            case (m_phase)
                0: begin
                    m_found = 1'b0;
                    m_win   = 0;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (!m_found && req[(m_ptr + k) % N_REQ]) begin
                            m_found = 1'b1;
                            m_win   = (m_ptr + k) % N_REQ;
                        end
                    end
                    if (m_found) begin
                        m_phase = 1;
                        m_age   = 0;
                        e_owner = m_win;
                        e_grant = '0;
                        e_grant[m_win] = 1'b1;
                    end
                end
                1: begin
                    e_x   = x_in[e_owner*8 +: 8];
                    e_y   = y_in[e_owner*7 +: 7];
                    e_col = colour_in[e_owner*3 +: 3];
                    m_quit_engine = done[e_owner] || !req[e_owner];
                    m_quit_wd     = (m_age + 1 == WD);
                    if (m_quit_engine || m_quit_wd) begin
                        m_phase = 2;
                        e_grant = '0;
                        e_to    = !m_quit_engine;
                    end else begin
                        e_we  = plot_in[e_owner] && (e_x < 160) && (e_y < 120);
                        m_age = m_age + 1;
                    end
                end
                default: begin
                    m_ptr   = (e_owner + 1) % N_REQ;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("grant", grant, e_grant);
            chk("owner", owner, e_owner);
            chk("busy", busy, m_phase != 0);
            chk("x", x, e_x);
            chk("y", y, e_y);
            chk("colour", colour, e_col);
            chk("writeEn", writeEn, e_we);
            chk("timeout_err", timeout_err, e_to);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int o);
        int n;
        n = 0;
        o = -1;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        chk("wait_grant", grant != '0, 1);
        if (grant != '0) o = int'(owner);
    endtask

    task automatic set_pix(input int e, input int px, input int py, input int pc);
        x_in[e*8 +: 8]      = 8'(px);
        y_in[e*7 +: 7]      = 7'(py);
        colour_in[e*3 +: 3] = 3'(pc);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int o;
        reset_n = 1'b0; req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        step();
        step();
        reset_n = 1'b1;
        chk("lit_reset_grant", grant, 4'b0000);
        chk("lit_reset_busy", busy, 1'b0);
        chk("lit_reset_we", writeEn, 1'b0);

        // Single requester
        req = 4'b0100;
        step();
        chk("lit_single_grant", grant, 4'b0100);
        plot_in = 4'b0100;
        set_pix(2, 10, 20, 5);
        step();
        chk("lit_single_x", x, 10);
        chk("lit_single_y", y, 20);
        chk("lit_single_colour", colour, 5);
        chk("lit_single_we", writeEn, 1'b1);
        plot_in = '0; done = 4'b0100; req = '0;
        step();
        done = '0;
        chk("lit_single_drop", grant, 4'b0000);
        step();
        step();

        // Contention from a fresh pointer
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(o);
            chk("lit_rr_owner", o, n % 4);
            step();
            step();
            done[o % 4] = 1'b1;
            step();
            done = '0;
            chk("lit_rr_release_we", writeEn, 1'b0);
            chk("lit_rr_release_grant", grant, 4'b0000);
        end
        req = '0;
        step();
        step();

        // Clipping
        req = 4'b0001;
        wait_grant(o);
        plot_in = 4'b0001;
        set_pix(0, 160, 5, 1);
        step();
        chk("lit_clip_x160", writeEn, 1'b0);
        set_pix(0, 159, 120, 2);
        step();
        chk("lit_clip_y120", writeEn, 1'b0);
        set_pix(0, 159, 119, 3);
        step();
        chk("lit_clip_in", writeEn, 1'b1);
        plot_in = '0; done = 4'b0001; req = '0;
        step();
        done = '0;
        step();
        step();

        // Watchdog, then another requester goes first
        req = 4'b0010;
        wait_grant(o);
        chk("lit_wd_owner", o, 1);
        req = 4'b1010;
        for (int i = 0; i < WD - 1; i++) step();
        chk("lit_wd_still", grant, 4'b0010);
        step();
        chk("lit_wd_drop", grant, 4'b0000);
        chk("lit_wd_to", timeout_err, 1'b1);
        step();
        chk("lit_wd_pulse", timeout_err, 1'b0);
        wait_grant(o);
        chk("lit_wd_next", o, 3);
        done = 4'b1000; req = 4'b0010;
        step();
        done = '0;
        chk("lit_first_cycle_done", grant, 4'b0000);
        wait_grant(o);
        chk("lit_wd_regrant", o, 1);

        // Abandon
        step();
        step();
        req = '0;
        step();
        chk("lit_abandon_drop", grant, 4'b0000);
        chk("lit_abandon_to", timeout_err, 1'b0);
        step();
        step();

        // done on the last watchdog cycle
        req = 4'b0100;
        wait_grant(o);
        for (int i = 0; i < WD - 1; i++) step();
        done = 4'b0100;
        step();
        done = '0;
        req  = '0;
        chk("lit_done_wd_drop", grant, 4'b0000);
        chk("lit_done_wd_to", timeout_err, 1'b0);
        step();
        step();

        // Reset mid-ACTIVE
        req = 4'b1000;
        wait_grant(o);
        plot_in = 4'b1000;
        set_pix(3, 50, 60, 7);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        plot_in = '0;
        chk("lit_rst_grant", grant, 4'b0000);
        chk("lit_rst_we", writeEn, 1'b0);
        chk("lit_rst_x", x, 0);
        chk("lit_rst_owner", owner, 0);
        chk("lit_rst_to", timeout_err, 1'b0);
        req = 4'b1111;
        wait_grant(o);
        chk("lit_rst_prio", o, 0);
        req = '0;
        step();
        step();
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
                done[i] = ($urandom_range(0, 9) == 0);
                x_in[i*8 +: 8]      = 8'($urandom_range(0, 175));
                y_in[i*7 +: 7]      = 7'($urandom_range(0, 127));
                colour_in[i*3 +: 3] = 3'($urandom);
            end
            plot_in = 4'($urandom);
            reset_n = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1;
        req = '0;
        done = '0;
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
